match_timer: RTL and testbench
==============================

Name: match_timer

Overview:
Parametrised successor to the 5-bit free-running match counter. It is a prescaled up-counter with start/stop/one-shot control and NCH independent compare channels. Each channel provides a combinational level match, a registered single-cycle match pulse and a sticky interrupt flag. It sits beside the pipeline as the generic timebase and event generator for test and sequencing logic.

Parameters:
WIDTH, 5, counter and compare width
NCH, 4, number of compare channels (>=1)
PSW, 4, prescaler width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
START  in  1  launch pulse: CNT<=0, PRE<=0, state->RUN
CLR  in  1  sync clear: CNT<=0, PRE<=0, state->IDLE
EN  in  1  run enable; 0 pauses the counter in RUN
ONESHOT  in  1  1 = stop at terminal count
MODE  in  1  0 = wrap at all-ones, 1 = wrap at PERIOD
PERIOD  in  WIDTH  terminal count when MODE=1
PRESCALE  in  PSW  tick every PRESCALE+1 enabled cycles
MATCH_VAL  in  NCH*WIDTH  channel i compare value at [i*WIDTH +: WIDTH]
MATCH_EN  in  NCH  per-channel enable
IRQ_CLR  in  NCH  per-channel sticky-flag clear
CNT  out  WIDTH  current count
RUNNING  out  1  state==RUN
WRAP  out  1  one-cycle pulse, terminal tick occurred
MATCH_OUT  out  NCH  combinational: MATCH_EN[i] & (CNT==MATCH_VAL[i])
MATCH_PULSE  out  NCH  registered single-cycle match event
IRQ  out  NCH  sticky match flag

Behaviour:
- Clock CLK; reset RST is asynchronous and active-high. Port names CLK and RST as in the codebase.
- Reset values: state IDLE, CNT=0, PRE=0, WRAP=0, MATCH_PULSE=0, IRQ=0, RUNNING=0. MATCH_OUT follows its combinational equation.
- States: IDLE, RUN, DONE. START: IDLE/DONE/RUN->RUN, restarts from 0. ONESHOT terminal tick: RUN->DONE. CLR: any->IDLE.
- Priority: CLR > START > tick. CLR and START together: CLR wins.
- Prescaler: ticks only in RUN with EN=1. tick = (PRE==PRESCALE); on tick PRE<=0, otherwise PRE<=PRE+1. With PRESCALE=0 there is a tick every cycle.
- TOP = MODE ? PERIOD : all-ones. On tick:
  - CNT==TOP and ONESHOT=0: CNT<=0, WRAP=1 next cycle.
  - CNT==TOP and ONESHOT=1: CNT holds TOP, WRAP=1 next cycle, state->DONE.
  - Otherwise CNT<=CNT+1, mod 2^WIDTH.
- PERIOD lowered below CNT mid-run: the counter continues to all-ones and rolls over to 0 with no WRAP. This is defined behaviour, not an error.
- Match event i = tick & MATCH_EN[i] & (CNT_next==MATCH_VAL[i]).
  - MATCH_PULSE[i] is the registered event, so it is high in the first cycle CNT shows the matching value.
  - START, CLR and reset loading 0 generate no event.
- IRQ[i] sets on event i and clears on IRQ_CLR[i]. Set wins when both occur in the same cycle.
- EN=0 in RUN: CNT, PRE and state hold. No pulses.
- DONE/IDLE: CNT holds; MATCH_OUT remains live against the held CNT.
- Reset mid-operation aborts immediately to the reset values.

Optional Feature:
MATCH_TIMER_CAPTURE_EN
- Defined:
  - Adds input CAPTURE (1) and outputs CAP_VAL (WIDTH) and CAP_VLD (1).
  - CAPTURE=1 loads CAP_VAL<=CNT (the pre-update value) and sets CAP_VLD.
  - START clears CAP_VLD. If CAPTURE and START occur in the same cycle, the capture wins.
  - CAP_VAL and CAP_VLD reset to 0.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, START, EN=1, PRESCALE=0, MODE=0, WIDTH=5 -> CNT counts 0..31 then 0. WRAP high for one cycle in the cycle CNT shows 0 after 31.
- MODE=1, PERIOD=9, PRESCALE=2 -> CNT advances every 3 cycles, sequence 0..9,0. Wrap period is 30 cycles.
- ONESHOT=1, MODE=1, PERIOD=4 -> CNT stops at 4, single WRAP, RUNNING=0, state DONE. A further START restarts from 0.
- Channel 0 MATCH_VAL=7, channel 1 MATCH_VAL=7 with MATCH_EN=01 -> MATCH_PULSE=01 once per wrap, in the cycle CNT first equals 7. IRQ[0] stays set until IRQ_CLR[0]. IRQ_CLR[0] in the same cycle as a new event leaves IRQ[0]=1.
- EN dropped for 5 cycles at CNT=12 -> CNT holds 12 with no repeat MATCH_PULSE. Counting resumes to 13 after EN=1 plus one prescale tick.
- Assert RST asynchronously mid-count, and assert CLR together with START -> all outputs return to reset values, state IDLE, and CNT=0 in the following cycle.

Source files
------------

// File: rtl/match_timer.sv
`default_nettype none
// ============================================================================
// Module   : match_timer
// Purpose  : Prescaled up-counter with start/stop/one-shot control and NCH
//            independent compare channels. Each channel has a combinational
//            level match, a registered single-cycle match pulse and a sticky
//            interrupt flag.
// Ports    : CLK, RST (async, active-high)
//            START / CLR / EN / ONESHOT / MODE     - run control
//            PERIOD, PRESCALE                      - terminal count, tick rate
//            MATCH_VAL, MATCH_EN, IRQ_CLR          - compare channels
//            CNT, RUNNING, WRAP                    - counter status
//            MATCH_OUT, MATCH_PULSE, IRQ           - per-channel outputs
// Option   : MATCH_TIMER_CAPTURE_EN adds CAPTURE / CAP_VAL / CAP_VLD.
// Revision : 1.0 - initial release
// ============================================================================
module match_timer #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int PSW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 CLR,
    input  logic                 EN,
    input  logic                 ONESHOT,
    input  logic                 MODE,
    input  logic [WIDTH-1:0]     PERIOD,
    input  logic [PSW-1:0]       PRESCALE,
    input  logic [NCH*WIDTH-1:0] MATCH_VAL,
    input  logic [NCH-1:0]       MATCH_EN,
    input  logic [NCH-1:0]       IRQ_CLR,
`ifdef MATCH_TIMER_CAPTURE_EN
    input  logic                 CAPTURE,
    output logic [WIDTH-1:0]     CAP_VAL,
    output logic                 CAP_VLD,
`endif
    output logic [WIDTH-1:0]     CNT,
    output logic                 RUNNING,
    output logic                 WRAP,
    output logic [NCH-1:0]       MATCH_OUT,
    output logic [NCH-1:0]       MATCH_PULSE,
    output logic [NCH-1:0]       IRQ
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_cnt_one  = WIDTH'(1);
    localparam logic [PSW-1:0]   c_pre_one  = PSW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_cnt;
    logic [PSW-1:0]   r_pre;
    logic             r_wrap;
    logic [NCH-1:0]   r_match_pulse;
    logic [NCH-1:0]   r_irq;

    logic             w_run_en;
    logic             w_tick;
    logic             w_advance;
    logic [WIDTH-1:0] w_top;
    logic             w_at_top;
    logic [WIDTH-1:0] w_cnt_step;
    logic [NCH-1:0]   w_event;

    assign w_run_en = (r_state == S_RUN) & EN;
    assign w_tick   = w_run_en & (r_pre == PRESCALE);
    // CLR and START both override a tick, so a tick only counts when neither is present.
    assign w_advance = w_tick & ~CLR & ~START;

    assign w_top    = MODE ? PERIOD : c_all_ones;
    // Equality (not >=) is deliberate: if PERIOD drops below CNT the count runs
    // on to all-ones and rolls over naturally without a WRAP.
    assign w_at_top = (r_cnt == w_top);
    assign w_cnt_step = w_at_top ? (ONESHOT ? r_cnt : '0) : (r_cnt + c_cnt_one);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign MATCH_OUT[gi] = MATCH_EN[gi] & (r_cnt == MATCH_VAL[gi*WIDTH +: WIDTH]);
            assign w_event[gi]   = w_advance & MATCH_EN[gi]
                                 & (w_cnt_step == MATCH_VAL[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (CLR) begin
            w_state_next = S_IDLE;
        end else if (START) begin
            w_state_next = S_RUN;
        end else if (w_advance && w_at_top && ONESHOT) begin
            w_state_next = S_DONE;
        end else if (r_state == 2'd3) begin
            w_state_next = S_IDLE;
        end
    end

    // Counter, prescaler and per-channel pulse/flag registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt         <= '0;
            r_pre         <= '0;
            r_wrap        <= 1'b0;
            r_match_pulse <= '0;
            r_irq         <= '0;
        end else begin
            if (CLR || START) begin
                r_cnt <= '0;
                r_pre <= '0;
            end else if (w_run_en) begin
                if (w_tick) begin
                    r_pre <= '0;
                    r_cnt <= w_cnt_step;
                end else begin
                    r_pre <= r_pre + c_pre_one;
                end
            end
            r_wrap        <= w_advance & w_at_top;
            r_match_pulse <= w_event;
            // Set wins over clear when both land in the same cycle.
            r_irq         <= (r_irq & ~IRQ_CLR) | w_event;
        end
    end

`ifdef MATCH_TIMER_CAPTURE_EN
    logic [WIDTH-1:0] r_cap_val;
    logic             r_cap_vld;

    // A capture in the same cycle as START wins, so CAP_VLD stays set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cap_val <= '0;
            r_cap_vld <= 1'b0;
        end else if (CAPTURE) begin
            r_cap_val <= r_cnt;
            r_cap_vld <= 1'b1;
        end else if (START) begin
            r_cap_vld <= 1'b0;
        end
    end

    assign CAP_VAL = r_cap_val;
    assign CAP_VLD = r_cap_vld;
`endif

    assign CNT         = r_cnt;
    assign RUNNING     = (r_state == S_RUN);
    assign WRAP        = r_wrap;
    assign MATCH_PULSE = r_match_pulse;
    assign IRQ         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_match_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_timer
// Purpose  : Self-checking bench for match_timer (default build) using a
//            behavioural reference model plus directed and random phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_timer;

    localparam int W = 5;
    localparam int N = 4;
    localparam int P = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           START, CLR, EN, ONESHOT, MODE;
    logic [W-1:0]   PERIOD;
    logic [P-1:0]   PRESCALE;
    logic [N*W-1:0] MATCH_VAL;
    logic [N-1:0]   MATCH_EN, IRQ_CLR;
    logic [W-1:0]   CNT;
    logic           RUNNING, WRAP;
    logic [N-1:0]   MATCH_OUT, MATCH_PULSE, IRQ;

    match_timer #(.WIDTH(W), .NCH(N), .PSW(P)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CLR(CLR), .EN(EN),
        .ONESHOT(ONESHOT), .MODE(MODE), .PERIOD(PERIOD), .PRESCALE(PRESCALE),
        .MATCH_VAL(MATCH_VAL), .MATCH_EN(MATCH_EN), .IRQ_CLR(IRQ_CLR),
        .CNT(CNT), .RUNNING(RUNNING), .WRAP(WRAP), .MATCH_OUT(MATCH_OUT),
        .MATCH_PULSE(MATCH_PULSE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers)
    int       m_cnt, m_pre;
    bit       m_running;
    bit       m_wrap;
    bit [N-1:0] m_pulse, m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int chan_val(input int i);
        logic [N*W-1:0] v;
        v = MATCH_VAL;
        return int'(v[i*W +: W]);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_running = 0; m_wrap = 0; m_pulse = '0; m_irq = '0;
    endtask

    // One clock edge of the timer, from the behavioural rules.
    task automatic model_edge();
        int top, nxt;
        bit [N-1:0] ev;
        ev = '0;
        m_wrap = 0;
        if (RST) begin
            model_reset();
            return;
        end
        top = MODE ? int'(PERIOD) : (1 << W) - 1;
        if (CLR) begin
            m_cnt = 0; m_pre = 0; m_running = 0;
        end else if (START) begin
            m_cnt = 0; m_pre = 0; m_running = 1;
        end else if (m_running && EN) begin
            if (m_pre == int'(PRESCALE)) begin
                m_pre = 0;
                if (m_cnt == top) begin
                    m_wrap = 1;
                    if (ONESHOT) begin
                        nxt = m_cnt;
                        m_running = 0;
                    end else begin
                        nxt = 0;
                    end
                end else begin
                    nxt = (m_cnt + 1) % (1 << W);
                end
                for (int i = 0; i < N; i++)
                    if (MATCH_EN[i] && nxt == chan_val(i)) ev[i] = 1'b1;
                m_cnt = nxt;
            end else begin
                m_pre = (m_pre + 1) % (1 << P);
            end
        end
        m_pulse = ev;
        m_irq   = (m_irq & ~IRQ_CLR) | ev;
    endtask

    task automatic check_all();
        bit [N-1:0] mo;
        for (int i = 0; i < N; i++) mo[i] = MATCH_EN[i] && (m_cnt == chan_val(i));
        chk("cnt",       32'(CNT),         32'(m_cnt));
        chk("running",   32'(RUNNING),     32'(m_running));
        chk("wrap",      32'(WRAP),        32'(m_wrap));
        chk("match_out", 32'(MATCH_OUT),   32'(mo));
        chk("pulse",     32'(MATCH_PULSE), 32'(m_pulse));
        chk("irq",       32'(IRQ),         32'(m_irq));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_ch(input int i, input int v);
        MATCH_VAL[i*W +: W] = W'(v);
    endtask

    initial begin
        int n, wraps, p0, p1;
        RST = 1; START = 0; CLR = 0; EN = 0; ONESHOT = 0; MODE = 0;
        PERIOD = '0; PRESCALE = '0; MATCH_VAL = '0; MATCH_EN = '0; IRQ_CLR = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        RST = 0;

        // Free-running wrap at all-ones
        START = 1; EN = 1;
        step();
        START = 0;
        wraps = 0;
        for (int k = 0; k < 34; k++) begin
            step();
            if (WRAP) begin
                wraps++;
                chk("wrap_at_zero", 32'(CNT), 32'd0);
            end
        end
        chk("wrap_count_free", 32'(wraps), 32'd1);

        // Period mode with prescale
        MODE = 1; PERIOD = 9; PRESCALE = 2;
        START = 1; step(); START = 0;
        for (int k = 0; k < 65; k++) step();

        // One-shot
        ONESHOT = 1; PERIOD = 4; PRESCALE = 0;
        START = 1; step(); START = 0;
        wraps = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (WRAP) wraps++;
        end
        chk("oneshot_cnt", 32'(CNT), 32'd4);
        chk("oneshot_run", 32'(RUNNING), 32'd0);
        chk("oneshot_wraps", 32'(wraps), 32'd1);
        START = 1; step(); START = 0;
        chk("restart_cnt", 32'(CNT), 32'd0);
        step(); step();

        // Match channels: ch0 and ch1 both at 7, only ch0 enabled
        ONESHOT = 0; MODE = 0;
        set_ch(0, 7); set_ch(1, 7); set_ch(2, 20); set_ch(3, 3);
        MATCH_EN = 4'b0001;
        START = 1; step(); START = 0;
        p0 = 0; p1 = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (MATCH_PULSE[0]) p0++;
            if (MATCH_PULSE[1]) p1++;
        end
        chk("pulses_ch0", 32'(p0), 32'd2);
        chk("pulses_ch1", 32'(p1), 32'd0);
        chk("irq0_sticky", 32'(IRQ[0]), 32'd1);
        n = 0;
        while (m_cnt != 6 && n < 100) begin step(); n++; end
        chk("wait_cnt6", 32'(n < 100), 32'd1);
        IRQ_CLR = 4'b0001; step(); IRQ_CLR = '0;
        chk("irq_set_wins", 32'(IRQ[0]), 32'd1);
        IRQ_CLR = 4'b0001; step(); IRQ_CLR = '0;
        chk("irq_cleared", 32'(IRQ[0]), 32'd0);

        // Pause at 12
        n = 0;
        while (m_cnt != 12 && n < 100) begin step(); n++; end
        chk("wait_cnt12", 32'(n < 100), 32'd1);
        EN = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("pause_hold", 32'(CNT), 32'd12);
            chk("pause_nopulse", 32'(MATCH_PULSE), 32'd0);
        end
        EN = 1; step();
        chk("resume_13", 32'(CNT), 32'd13);
        step(); step();

        // Asynchronous reset between edges
        @(negedge CLK); #2;
        RST = 1;
        #1;
        model_reset();
        check_all();
        step();
        RST = 0;
        START = 1; step(); START = 0;
        for (int k = 0; k < 5; k++) step();

        // CLR together with START: CLR wins
        CLR = 1; START = 1; step(); CLR = 0; START = 0;
        chk("clr_start_cnt", 32'(CNT), 32'd0);
        chk("clr_start_idle", 32'(RUNNING), 32'd0);
        step();

        // Random phase
        for (int k = 0; k < 1500; k++) begin
            START   = ($urandom_range(0, 24) == 0);
            CLR     = ($urandom_range(0, 79) == 0);
            EN      = ($urandom_range(0, 4) != 0);
            IRQ_CLR = N'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                MODE     = 1'($urandom);
                ONESHOT  = ($urandom_range(0, 3) == 0);
                PERIOD   = W'($urandom);
                PRESCALE = P'($urandom_range(0, 3));
                MATCH_EN = N'($urandom);
                for (int i = 0; i < N; i++) set_ch(i, $urandom_range(0, (1 << W) - 1));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
